bitonic_topk_merge: RTL and testbench
=====================================

Name: bitonic_topk_merge

Overview:
- Pipelined bitonic merger that sits directly downstream of the max_k stage.
- Takes max_k's K-element bitonic vector, which holds the K largest values of the two source lists in bitonic order, and produces those K values fully sorted ascending.
- Built as log2(K) registered compare-exchange layers with a valid/ready handshake on both sides.

Parameters:
- K, 16, number of 16-bit signed elements per vector; power of two, K >= 2.
- LOG2K, $clog2(K), number of merge layers; derived, not overridden.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  in_data holds a valid bitonic vector.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  K*16  bitonic vector from max_k largest_out; element i at bits [16i +: 16], signed.
- out_valid  output  1  out_data holds a sorted vector.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  K*16  sorted vector, ascending; element 0 is the smallest, element K-1 the largest.

Behaviour:
- Clock and reset: single clock domain, clk. rst is synchronous and active-high.
- Reset values: all stage valid bits 0, all stage data registers 0, out_valid 0, out_data 0.
- Layer structure: LOG2K layers, s = 0..LOG2K-1.
  - Layer s has distance d = K >> (s+1).
  - For each i with (i & d) == 0, compare element i with element i+d.
  - The smaller value (signed compare) goes to i, the larger to i+d. Equal values pass through unchanged.
- Registers and latency: each layer's result is registered together with a valid bit. The last layer's register drives out_data and out_valid. Latency is exactly LOG2K cycles from the accepting in_valid & in_ready edge to out_valid, with out_ready held high.
- Flow control is a global-stall scheme:
  - en = out_ready | ~out_valid.
  - in_ready = en, combinational from out_ready and out_valid only.
  - When en = 1, every layer register loads from its predecessor. Layer 0 loads in_data and valid = in_valid & in_ready.
  - When en = 0, all registers hold.
  - Bubbles inside the pipeline are not compressed.
- Throughput: one vector per cycle while out_ready = 1.
- Data stability: out_data and out_valid stay stable while out_valid = 1 and out_ready = 0.
- Simultaneous events: out_ready = 1 while out_valid = 1 and in_valid = 1 means the output transfer and the input acceptance happen in the same cycle.
- Reset mid-operation: in-flight vectors are discarded. out_valid goes low on the cycle after rst is sampled high. No partial vector is ever presented.
- Input contract: the input is assumed bitonic; non-bitonic input gives an undefined ordering. The block still passes exactly K values through, as a permutation of in_data.
- Arithmetic: pure compare-exchange, no width growth. 0x8000 (-32768) is the minimum and 0x7FFF the maximum.

Decomposition:
- Shared package holds:
  - ELEM_W = 16.
  - The signed 16-bit element typedef.
  - A K-element packed vector typedef.
  - A clog2-based LOG2K helper.
- Sub-module bitonic_merge_layer: one compare-exchange layer, parameters K and D. Comparators are compare_swap_asc instances; the layer register and valid bit sit inside, gated by en. The top level generates LOG2K instances.

Test Plan:
- Reset and idle: K=4, rst high 2 cycles, then in_valid=0 -> out_valid=0, out_data=0, in_ready=1.
- Basic sort and latency: K=4, in_data={7,5,6,8} (element 3..0, i.e. max_k output of asc {1,3,5,7} vs desc {8,6,4,2}), out_ready=1 -> out_data elements 0..3 = {5,6,7,8}, out_valid exactly 2 cycles after acceptance.
- Signed and boundary values:
  - K=4, elements 0..3 = {10,0,-2,-1} -> out elements 0..3 = {-2,-1,0,10}.
  - Elements 0..3 = {32767,-32768,-32768,32767} -> {-32768,-32768,32767,32767}.
- Back-pressure: K=16, stream 20 random bitonic vectors with out_ready toggling pseudo-randomly -> no loss or duplication, order preserved, out_data stable while stalled, each output equals a golden ascending sort of its input.
- Full throughput: K=16, in_valid and out_ready held 1 for 50 cycles -> out_valid continuous from cycle 4 after the first acceptance, one result per cycle.
- Reset mid-flight: 3 vectors in the pipeline, out_ready=0, assert rst for 1 cycle -> out_valid=0 on the next cycle, and none of the 3 vectors appears afterwards.

Source files
------------

// File: rtl/bitonic_topk_merge_pkg.sv
// Shared types and helpers for the bitonic top-K merger.
// Defines the signed element type, a default-width vector type and the
// layer-count helper used by the top level.
package bitonic_topk_merge_pkg;

   localparam int unsigned ELEM_W    = 16;
   localparam int unsigned K_DEFAULT = 16;

   typedef logic signed [ELEM_W-1:0] elem_t;
   typedef elem_t [K_DEFAULT-1:0]     vec_t;

   // Number of compare-exchange layers needed to merge a k-element bitonic vector.
   function automatic int unsigned log2k(input int unsigned k);
      return $clog2(k);
   endfunction

endpackage

// File: rtl/bitonic_topk_merge_layer.sv
// One bitonic compare-exchange layer plus its pipeline register.
//
// compare_swap_asc ports:
//   a_i, b_i   - signed elements in
//   lo_c_o     - smaller of the two (combinational)
//   hi_c_o     - larger of the two (combinational)
//
// bitonic_merge_layer ports:
//   clk, rst   - clock, synchronous active-high reset
//   en_i       - global pipeline enable; register holds when low
//   valid_i    - valid bit of the incoming vector
//   data_i     - K-element vector from the previous layer
//   valid_o    - registered valid bit
//   data_o     - registered K-element vector after compare-exchange at distance D

module compare_swap_asc
   import bitonic_topk_merge_pkg::*;
(
   input  elem_t a_i,
   input  elem_t b_i,
   output elem_t lo_c_o,
   output elem_t hi_c_o
);

   logic swap_c;

   // Swap only on strict greater-than so equal values pass straight through.
   assign swap_c = (a_i > b_i);
   assign lo_c_o = swap_c ? b_i : a_i;
   assign hi_c_o = swap_c ? a_i : b_i;

endmodule

module bitonic_merge_layer
   import bitonic_topk_merge_pkg::*;
#(
   parameter int unsigned K = 16,
   parameter int unsigned D = 8
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          en_i,
   input  logic          valid_i,
   input  elem_t [K-1:0] data_i,
   output logic          valid_o,
   output elem_t [K-1:0] data_o
);

   elem_t [K-1:0] data_d;
   elem_t [K-1:0] data_q;
   logic          valid_q;

   // Pair every index with bit D clear against its partner D above it.
   for (genvar i = 0; i < int'(K); i++) begin : g_pair
      if ((i & int'(D)) == 0) begin : g_cas
         compare_swap_asc u_cas (
            .a_i    (data_i[i]),
            .b_i    (data_i[i+int'(D)]),
            .lo_c_o (data_d[i]),
            .hi_c_o (data_d[i+int'(D)])
         );
      end
   end

   // Pipeline register; the whole pipe stalls together on en_i.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (en_i) begin
         data_q  <= data_d;
         valid_q <= valid_i;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/bitonic_topk_merge.sv
// Pipelined bitonic merger: sorts a K-element bitonic vector ascending
// through log2(K) registered compare-exchange layers, with a global stall.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   in_valid   - in_data carries a bitonic vector
//   in_ready   - block accepts in_data this cycle (combinational)
//   in_data    - K signed 16-bit elements, element i at [16i +: 16]
//   out_valid  - out_data carries a sorted vector
//   out_ready  - consumer accepts out_data this cycle
//   out_data   - sorted vector, element 0 smallest
module bitonic_topk_merge
   import bitonic_topk_merge_pkg::*;
#(
   parameter int unsigned K = 16
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [K*ELEM_W-1:0]   in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [K*ELEM_W-1:0]   out_data
);

   localparam int unsigned LOG2K = log2k(K);

   logic          en;
   logic          stage_valid [LOG2K+1];
   elem_t [K-1:0] stage_data  [LOG2K+1];

   // Whole pipe advances whenever the output slot is free or being drained.
   assign en       = out_ready | ~out_valid;
   assign in_ready = en;

   assign stage_valid[0] = in_valid & en;
   assign stage_data[0]  = in_data;

   // Layer s compares at distance K >> (s+1): K/2, K/4, ..., 1.
   for (genvar s = 0; s < int'(LOG2K); s++) begin : g_layer
      bitonic_merge_layer #(
         .K (K),
         .D (K >> (s + 1))
      ) u_layer (
         .clk     (clk),
         .rst     (rst),
         .en_i    (en),
         .valid_i (stage_valid[s]),
         .data_i  (stage_data[s]),
         .valid_o (stage_valid[s+1]),
         .data_o  (stage_data[s+1])
      );
   end

   assign out_valid = stage_valid[LOG2K];
   assign out_data  = stage_data[LOG2K];

endmodule

// File: tb/tb_bitonic_topk_merge.sv
// Bench for bitonic_topk_merge: a K=4 instance for directed table vectors
// and a K=16 instance for streaming, back-pressure and reset scenarios.
module tb_bitonic_topk_merge;

   logic clk;
   logic rst;

   // K=4 instance
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [63:0] a_in_data, a_out_data;
   // K=16 instance
   logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [255:0] b_in_data, b_out_data;

   int n_checks;
   int n_pass;

   bitonic_topk_merge #(.K(4)) u_dut4 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_data   (a_in_data),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_data  (a_out_data)
   );

   bitonic_topk_merge #(.K(16)) u_dut16 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_data   (b_in_data),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_data  (b_out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic chk_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", name, act, exp);
   endtask

   function automatic logic [63:0] pack4(input int e0, input int e1, input int e2, input int e3);
      return {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
   endfunction

   // Reference: plain insertion sort, ascending, signed.
   function automatic logic [255:0] golden_sort16(input logic [255:0] v);
      shortint      a [16];
      shortint      t;
      logic [255:0] r;
      for (int i = 0; i < 16; i++) a[i] = shortint'(v[16*i +: 16]);
      for (int i = 1; i < 16; i++) begin
         t = a[i];
         for (int j = i - 1; j >= 0; j--) begin
            if (a[j] > t) begin
               a[j+1] = a[j];
               a[j]   = t;
            end
         end
      end
      for (int i = 0; i < 16; i++) r[16*i +: 16] = 16'(a[i]);
      return r;
   endfunction

   // Random bitonic vector: sorted values split into a rising front and falling back.
   function automatic logic [255:0] gen_bitonic16();
      logic [255:0] s;
      logic [255:0] r;
      shortint      back [$];
      int           n;
      for (int i = 0; i < 16; i++) s[16*i +: 16] = 16'($urandom);
      s = golden_sort16(s);
      n = 0;
      for (int i = 0; i < 16; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            r[16*n +: 16] = s[16*i +: 16];
            n++;
         end else begin
            back.push_back(shortint'(s[16*i +: 16]));
         end
      end
      for (int j = back.size() - 1; j >= 0; j--) begin
         r[16*n +: 16] = 16'(back[j]);
         n++;
      end
      return r;
   endfunction

   typedef struct {
      logic [63:0] din;
      logic [63:0] dexp;
   } vec4_t;

   vec4_t        tbl [7];
   logic [255:0] bp_in  [20];
   logic [255:0] bp_exp [20];
   logic [255:0] tp_in  [50];
   logic [255:0] tp_exp [50];

   initial begin : main
      int           sent, got, cyc, extra;
      logic         acc, prev_stall;
      logic [255:0] prev_data;

      n_checks = 0;
      n_pass   = 0;

      tbl[0] = '{pack4(8, 6, 5, 7),                 pack4(5, 6, 7, 8)};
      tbl[1] = '{pack4(10, 0, -2, -1),              pack4(-2, -1, 0, 10)};
      tbl[2] = '{pack4(32767, -32768, -32768, 32767), pack4(-32768, -32768, 32767, 32767)};
      tbl[3] = '{pack4(3, 3, 3, 3),                 pack4(3, 3, 3, 3)};
      tbl[4] = '{pack4(1, 2, 3, 4),                 pack4(1, 2, 3, 4)};
      tbl[5] = '{pack4(4, 3, 2, 1),                 pack4(1, 2, 3, 4)};
      tbl[6] = '{pack4(0, 5, 9, -3),                pack4(-3, 0, 5, 9)};

      rst         = 1'b1;
      a_in_valid  = 1'b0;
      a_in_data   = '0;
      a_out_ready = 1'b1;
      b_in_valid  = 1'b0;
      b_in_data   = '0;
      b_out_ready = 1'b1;

      // Reset and idle
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_bit("idle4_out_valid", a_out_valid, 1'b0);
      chk_vec("idle4_out_data", 256'(a_out_data), '0);
      chk_bit("idle4_in_ready", a_in_ready, 1'b1);
      chk_bit("idle16_out_valid", b_out_valid, 1'b0);
      chk_vec("idle16_out_data", b_out_data, '0);
      @(posedge clk); #1;

      // K=4 table: one vector at a time, latency exactly 2 cycles
      for (int v = 0; v < 7; v++) begin
         a_in_valid = 1'b1;
         a_in_data  = tbl[v].din;
         @(negedge clk);
         chk_bit($sformatf("t%0d_in_ready", v), a_in_ready, 1'b1);
         @(posedge clk); #1;
         a_in_valid = 1'b0;
         @(negedge clk);
         chk_bit($sformatf("t%0d_early_valid", v), a_out_valid, 1'b0);
         @(posedge clk); #1;
         @(negedge clk);
         chk_bit($sformatf("t%0d_out_valid", v), a_out_valid, 1'b1);
         chk_vec($sformatf("t%0d_out_data", v), 256'(a_out_data), 256'(tbl[v].dexp));
         @(posedge clk); #1;
         @(negedge clk);
         chk_bit($sformatf("t%0d_drained", v), a_out_valid, 1'b0);
         @(posedge clk); #1;
      end

      // K=16 back-pressure stream
      for (int i = 0; i < 20; i++) begin
         bp_in[i]  = gen_bitonic16();
         bp_exp[i] = golden_sort16(bp_in[i]);
      end
      sent = 0; got = 0; prev_stall = 1'b0; prev_data = '0;
      for (cyc = 0; cyc < 2000 && got < 20; cyc++) begin
         b_in_valid  = (sent < 20);
         b_in_data   = (sent < 20) ? bp_in[sent] : '0;
         b_out_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         acc = b_in_valid && b_in_ready;
         if (prev_stall) begin
            chk_bit("bp_stall_valid", b_out_valid, 1'b1);
            chk_vec("bp_stall_data", b_out_data, prev_data);
         end
         if (b_out_valid && b_out_ready) begin
            chk_vec($sformatf("bp_out%0d", got), b_out_data, bp_exp[got]);
            got++;
         end
         prev_stall = b_out_valid && !b_out_ready;
         prev_data  = b_out_data;
         @(posedge clk); #1;
         if (acc) sent++;
      end
      if (got < 20) $display("FAIL bp_timeout: got %0d outputs expected 20", got);
      chk_vec("bp_count", 256'(got), 256'(20));
      b_in_valid  = 1'b0;
      b_out_ready = 1'b1;
      extra = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (b_out_valid) extra++;
         @(posedge clk); #1;
      end
      chk_vec("bp_no_dup", 256'(extra), '0);

      // K=16 full throughput: first result in cycle 4, then one per cycle
      for (int i = 0; i < 50; i++) begin
         tp_in[i]  = gen_bitonic16();
         tp_exp[i] = golden_sort16(tp_in[i]);
      end
      for (int c = 0; c < 56; c++) begin
         b_in_valid = (c < 50);
         b_in_data  = (c < 50) ? tp_in[c] : '0;
         @(negedge clk);
         if (c < 50) chk_bit($sformatf("tp_in_ready%0d", c), b_in_ready, 1'b1);
         chk_bit($sformatf("tp_valid%0d", c), b_out_valid, (c >= 4) && (c < 54));
         if (c >= 4 && c < 54)
            chk_vec($sformatf("tp_data%0d", c), b_out_data, tp_exp[c-4]);
         @(posedge clk); #1;
      end
      b_in_valid = 1'b0;

      // Reset mid-flight with three vectors inside and the output stalled
      b_out_ready = 1'b0;
      for (int v = 0; v < 3; v++) begin
         b_in_valid = 1'b1;
         b_in_data  = gen_bitonic16();
         @(negedge clk);
         chk_bit($sformatf("rm_in_ready%0d", v), b_in_ready, 1'b1);
         @(posedge clk); #1;
      end
      b_in_valid = 1'b0;
      @(negedge clk);
      chk_bit("rm_not_yet_valid", b_out_valid, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk_bit("rm_stalled_valid", b_out_valid, 1'b1);
      chk_bit("rm_stalled_in_ready", b_in_ready, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_bit("rm_valid_after_rst", b_out_valid, 1'b0);
      chk_vec("rm_data_after_rst", b_out_data, '0);
      b_out_ready = 1'b1;
      extra = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (b_out_valid) extra++;
      end
      chk_vec("rm_no_ghosts", 256'(extra), '0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
